// File: rtl/writeback_stage.sv
// Final pipeline stage: turns completed execute results, or load data, into register-file writes.
// Latency: ALU op writes 1 cycle after accept; a load writes 1 cycle after mem_rvalid (3 cycles minimum).
// Backpressure: in_ready is high only in IDLE or WRITE, so loads stall execute until their data returns.
module writeback_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_result,
    input  logic             in_mem_to_reg,
    input  logic             in_reg_write,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             wb_we,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retire_count
);

    localparam int          TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [31:0] TMO = 32'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, WRITE} state_t;

    state_t        state_q, state_d;
    logic [4:0]    rd_q;
    logic          rw_q;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          accept;
    logic          we_d;

    assign in_ready = (state_q == IDLE) || (state_q == WRITE);
    assign busy     = (state_q != IDLE);
    assign mem_req  = (state_q == MEM_REQ);
    assign accept   = in_valid && in_ready;
    assign tmo_hit  = (TIMEOUT > 0) && ((32'(tmo_cnt) + 32'd1) == TMO);

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        case (state_q)
            IDLE, WRITE: begin
                if (in_valid) begin
                    if (in_mem_to_reg) begin
                        state_d = MEM_REQ;
                    end else begin
                        state_d = WRITE;
                        we_d    = in_reg_write && (in_rd != 5'd0);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MEM_REQ: state_d = MEM_WAIT;
            MEM_WAIT: begin
                if (mem_rvalid) begin
                    state_d = WRITE;
                    we_d    = rw_q && (rd_q != 5'd0);
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            mem_addr     <= '0;
            tmo_cnt      <= '0;
            wb_we        <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            timeout_err  <= 1'b0;
            retire_count <= '0;
        end else begin
            state_q <= state_d;
            wb_we   <= we_d;
            if (accept) begin
                rd_q <= in_rd;
                rw_q <= in_reg_write;
                if (in_mem_to_reg) mem_addr <= in_result;
            end
            // wb_addr/wb_data only move when a real write is issued, so they hold otherwise
            if (we_d) begin
                if (state_q == MEM_WAIT) begin
                    wb_addr <= rd_q;
                    wb_data <= mem_rdata;
                end else begin
                    wb_addr <= in_rd;
                    wb_data <= in_result;
                end
            end
            if (state_q == MEM_WAIT) tmo_cnt <= tmo_cnt + TW'(1);
            else                     tmo_cnt <= '0;
            if (state_q == MEM_WAIT && !mem_rvalid && tmo_hit) timeout_err <= 1'b1;
            if (state_q == WRITE) retire_count <= retire_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Takes completed instructions from execute and produces the register-file write port: write address, write data and write enable.
- For loads it issues a single data-memory read and waits for the returned data before writing.
- Non-load results are written directly.
- Also keeps a retired-instruction count and a sticky memory-timeout error flag.

Parameters:
TIMEOUT, 16, max cycles to wait in MEM_WAIT for mem_rvalid; 0 disables the timeout
CNT_W, 32, width of retire_count

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  execute presents an instruction
in_ready  output  1  stage can accept this cycle
in_rd  input  5  destination register
in_result  input  32  ALU result; this is the memory address when in_mem_to_reg=1
in_mem_to_reg  input  1  instruction is a load
in_reg_write  input  1  instruction writes a register
mem_req  output  1  one-cycle data-memory read request
mem_addr  output  32  read address
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data
wb_we  output  1  register-file write enable
wb_addr  output  5  register-file write address
wb_data  output  32  register-file write data
busy  output  1  state != IDLE
timeout_err  output  1  sticky: a load timed out
retire_count  output  CNT_W  instructions retired

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; all outputs 0 except in_ready=1; internal latches and timeout counter cleared. Reset takes effect immediately, including mid-MEM_WAIT: the pending load is dropped, no write occurs, and a later mem_rvalid is ignored.
- States: IDLE, MEM_REQ, MEM_WAIT, WRITE.
- in_ready = (state==IDLE) || (state==WRITE), combinational from state.
- Accept: a transfer occurs at a rising edge where in_valid && in_ready. All in_* fields are latched at that edge.
  - in_mem_to_reg=1: next state MEM_REQ.
  - in_mem_to_reg=0: next state WRITE, with wb_data = in_result.
  - No accept: IDLE stays IDLE; WRITE goes to IDLE.
- MEM_REQ (exactly 1 cycle): mem_req=1 and mem_addr = latched address. Next state MEM_WAIT. mem_rvalid is ignored in this state.
- MEM_WAIT: mem_req=0 and mem_addr holds its value.
  - mem_rvalid=1: latch mem_rdata into wb_data, go to WRITE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT (TIMEOUT>0): set timeout_err, go to IDLE, no write, no retire.
  - Minimum load latency: accept edge, then MEM_REQ cycle, then mem_rvalid in the first MEM_WAIT cycle, then the WRITE cycle.
- WRITE (1 cycle):
  - wb_we = latched reg_write && (latched rd != 0).
  - wb_addr = latched rd.
  - The register file captures the write at the edge ending this cycle.
  - retire_count increments by 1 at that edge whether or not wb_we=1. It wraps modulo 2^CNT_W.
  - A new instruction may be accepted at the same edge, giving ALU-op throughput of 1 per cycle.
- wb_addr and wb_data hold their last values while wb_we=0. Outputs are registered or decoded purely from state; there is no combinational path from in_* to wb_*.
- mem_rvalid outside MEM_WAIT is ignored.
- Write to r0: the instruction retires, but wb_we stays 0.
- timeout_err clears only on reset.

Test Plan:
- Back-to-back ALU ops: (rd=5, result=0x1234, reg_write=1), then (rd=6, result=0xABCD) on consecutive cycles with in_valid held -> wb_we=1 on two consecutive cycles, writing 0x1234 to r5 then 0xABCD to r6; in_ready stays 1; retire_count=2.
- Load, rdata latency 3 cycles after mem_req: rd=8, address 0x40, rdata=0xDEADBEEF -> mem_req exactly 1 cycle with mem_addr=0x40; in_ready=0 and busy=1 until WRITE; single wb_we pulse writing r8=0xDEADBEEF.
- Write to r0, and reg_write=0: rd=0, reg_write=1 -> wb_we stays 0 and retire_count increments. Same result for rd=3, reg_write=0.
- Timeout with TIMEOUT=4: load with mem_rvalid never asserted -> return to IDLE 4 cycles after entering MEM_WAIT; timeout_err=1 and stays set; no wb_we; retire_count unchanged; next ALU op proceeds normally.
- Reset mid-MEM_WAIT: assert rst_n=0 asynchronously between edges -> outputs clear immediately. After release, a mem_rvalid pulse is ignored, with no wb_we.
- Stray mem_rvalid in IDLE and in MEM_REQ -> no state change, no write.
